turn_signal_conditioner: RTL

//  Upstream stage of the '65 Thunderbird taillight sequencer. Takes raw, asynchronous

---
 rtl/turn_signal_conditioner_if.sv | 21 ++
 rtl/turn_signal_conditioner.sv | 84 ++++++++
 2 files changed

// File: rtl/turn_signal_conditioner_if.sv
// Signal bundle between the raw lever/hazard switches and the taillight sequencer.
// The conditioner itself connects through the slave modport.
interface turn_signal_conditioner_if;
  logic left_raw;
  logic right_raw;
  logic hazard_raw;
  logic left;
  logic right;
  logic tick;
  logic busy;

  modport master (
    output left_raw, right_raw, hazard_raw,
    input  left, right, tick, busy
  );

  modport slave (
    input  left_raw, right_raw, hazard_raw,
    output left, right, tick, busy
  );
endinterface

// File: rtl/turn_signal_conditioner.sv
// Synchronises and debounces the turn/hazard switches, resolves them into left/right
// requests for the Thunderbird taillight sequencer, and paces it with a step tick.
module turn_signal_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input logic                      clk,
  input logic                      reset,
  turn_signal_conditioner_if.slave sig
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} state_e;

  // Bit order everywhere: [0]=left, [1]=right, [2]=hazard.
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    db_q, db_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          left_c, right_c, busy_c, tick_c;

  assign raw = {sig.hazard_raw, sig.right_raw, sig.left_raw};

  // A debounce counter only survives while s2 keeps disagreeing with the held level,
  // so any agreeing sample throws away the partial count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) db_d[i] = s2_q[i];
        else                                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    if (db_q[2] || (db_q[0] && db_q[1])) state_d = HAZARD;
    else if (db_q[0])                    state_d = LEFT;
    else if (db_q[1])                    state_d = RIGHT;

    tcnt_d = '0;
    if (state_d == state_q && state_q != IDLE && tcnt_q != TW'(TICK_DIV - 1))
      tcnt_d = tcnt_q + 1'b1;

    left_c  = (state_q == LEFT)  || (state_q == HAZARD);
    right_c = (state_q == RIGHT) || (state_q == HAZARD);
    busy_c  = (state_q != IDLE);
    // A pending state change on the wrap edge swallows that step.
    tick_c  = busy_c && (tcnt_q == TW'(TICK_DIV - 1)) && (state_d == state_q);
  end

  // NOTE: every flop, including the counter array, is cleared by reset so the
  // outputs are defined from the first cycle without relying on power-up values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q <= IDLE;
      tcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_q    <= raw;
      s2_q    <= s1_q;
      db_q    <= db_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign sig.left  = left_c;
  assign sig.right = right_c;
  assign sig.busy  = busy_c;
  assign sig.tick  = tick_c;
endmodule
